serial_arbiter: RTL
===================

Name: serial_arbiter

Overview:
- Shares one UART `transmit` instance between N byte-stream requesters.
- Round-robin grant. Each grant holds the channel for a burst of up to LEN bytes. Bytes pass unmodified to the transmitter's stb/rdy/dat port.
- Sits between on-chip producers (e.g. debug dump, status reporter) and the single serial TX line.

Parameters:
- N, 4, number of requesters (2..16)
- LEN, 16, maximum bytes per grant before forced rotation (1..256)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- req_stb  input  N  per-requester byte valid
- req_dat  input  N*8  per-requester byte; requester i uses bits [8i+7:8i]
- req_rdy  output  N  per-requester accept
- tx_stb  output  1  byte valid to transmit
- tx_dat  output  8  byte to transmit
- tx_rdy  input  1  transmit ready
- busy  output  1  a grant is active
- gnt  output  $clog2(N)  index of current or last granted requester

Behaviour:
- Interface and reset:
  - Handshake on both sides: a transfer occurs on a clk edge where stb && rdy. Requester holds stb and dat stable until accepted.
  - Reset (rst low, asynchronous): state IDLE, tx_stb 0, tx_dat 0, req_rdy 0, busy 0, gnt 0, rotation pointer ptr 0, burst count 0.
- FSM states: IDLE, TAG (only with the optional feature), DATA.
- IDLE:
  - If any req_stb is high, select the first set bit searching from ptr upward, wrapping modulo N.
  - Register the selection into gnt, set busy, clear count.
  - Next state is DATA, or TAG if the feature is enabled.
  - No byte is transferred in IDLE; grant latency is 1 cycle from req_stb to DATA.
- DATA, combinational pass-through:
  - tx_stb = req_stb[gnt]; tx_dat = req_dat[gnt].
  - req_rdy[gnt] = tx_rdy; all other req_rdy are 0.
- DATA, accounting and exit:
  - Each transfer increments count.
  - Exit to IDLE after the transfer that makes count == LEN.
  - Also exit to IDLE on any cycle where req_stb[gnt] is 0; the requester dropped out and no transfer occurs that cycle.
  - On exit: ptr = (gnt+1) mod N, busy 0.
- Fairness: a requester that stays asserted waits at most (N-1) grants. Non-granted requesters see req_rdy 0 throughout.
- Simultaneous events:
  - Request arrival during DATA is ignored until the next IDLE.
  - If only the current requester is pending at exit, it is re-granted after one IDLE cycle.
- Reset mid-burst: abort immediately. Any byte not yet handshaken is not transferred. tx_stb drops asynchronously.
- Width rule: count is $clog2(LEN+1) bits and never wraps.

Optional Feature:
- Macro: SERIAL_ARBITER_TAG_EN.
- Defined:
  - After each grant, state TAG emits one header byte before the payload: tx_dat = {4'hA, 4'(gnt)}, tx_stb = 1, all req_rdy 0.
  - Advance to DATA on tx_rdy. The tag does not count toward LEN.
  - Reset in TAG returns to IDLE.
- Undefined: TAG state is absent; IDLE goes directly to DATA. Receivers get raw interleaved bytes.

Test Plan:
- Single requester 0 sends 0x55, 0xAA -> serial line carries 0x55, 0xAA in order; req_rdy[1..3] stay 0; busy falls after the second byte is accepted.
- Requesters 0 and 2 each hold 3 bytes (0x10..0x12, 0x30..0x32) from the same cycle, LEN=16 -> output 0x10,0x11,0x12,0x30,0x31,0x32; gnt goes 0 then 2.
- LEN=2, requesters 1 and 3 continuously asserted -> output alternates two bytes from 1, two from 3, repeating; no requester starves.
- Requester 3 granted with ptr at 3, then requester 0 requests -> wrap-around grants 3, then 0; ptr returns to 0 after 3.
- Reset asserted while tx_stb high mid-burst -> tx_stb, busy and req_rdy go 0 without waiting for clk; the next grant after release starts at requester 0.
- With SERIAL_ARBITER_TAG_EN, requester 2 sends 0x7E -> receiver captures 0xA2 then 0x7E with err 0, checked through the receive/transmit loop at BAUD 9600, FREQ 12 MHz.

Source files
------------

// File: rtl/serial_arbiter.sv
// ============================================================================
// Module   : serial_arbiter
// Purpose  : Shares one UART transmitter between N byte-stream requesters.
//            Requesters are served round-robin. Each grant holds the channel
//            for a burst of at most LEN bytes. Bytes pass unmodified to the
//            transmitter's stb/rdy/dat port.
// Revision : 1.0 - initial release
//
// Parameters
//   N    number of requesters (2..16)
//   LEN  maximum bytes per grant before forced rotation (1..256)
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous reset, active-low
//   req_stb  in   [N]    per-requester byte valid
//   req_dat  in   [N*8]  per-requester byte, requester i on [8i+7:8i]
//   req_rdy  out  [N]    per-requester accept (only the granted one moves)
//   tx_stb   out         byte valid to transmitter
//   tx_dat   out  [8]    byte to transmitter
//   tx_rdy   in          transmitter ready
//   busy     out         a grant is active
//   gnt      out  [$clog2(N)]  current or last granted requester
//
// Optional feature (macro SERIAL_ARBITER_TAG_EN)
//   When defined, each grant first emits a header byte {4'hA, gnt} from
//   the TAG state. The header does not count toward LEN.
// ============================================================================
`default_nettype none

module serial_arbiter #(
  parameter int N   = 4,
  parameter int LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_stb,
  input  logic [N*8-1:0]       req_dat,
  output logic [N-1:0]         req_rdy,
  output logic                 tx_stb,
  output logic [7:0]           tx_dat,
  input  logic                 tx_rdy,
  output logic                 busy,
  output logic [$clog2(N)-1:0] gnt
);

  localparam int GW = $clog2(N);
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(LEN);
  localparam logic [GW-1:0] LAST_C = GW'(N - 1);

`ifdef SERIAL_ARBITER_TAG_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_DATA = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd2
  } state_t;
`endif

  state_t          state, state_nx;
  logic [GW-1:0]   gnt_nx;
  logic [GW-1:0]   ptr, ptr_nx;
  logic [CW-1:0]   count, count_nx;

  logic            sel_found;
  logic [GW-1:0]   sel_idx;
  logic [GW-1:0]   gnt_inc;

  // Round-robin search: walk from ptr upward with wrap. The loop runs
  // downward so the candidate closest to ptr is the last one assigned.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_stb[(int'(ptr) + i) % N]) begin
        sel_found = 1'b1;
        sel_idx   = GW'((int'(ptr) + i) % N);
      end
    end
  end

  // Modulo-N increment; N need not be a power of two.
  assign gnt_inc = (gnt == LAST_C) ? '0 : gnt + 1'b1;

  // State register. Outputs are decoded from state, so an asynchronous
  // reset drops tx_stb / req_rdy / busy without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      ptr   <= ptr_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    ptr_nx   = ptr;
    count_nx = count;
    tx_stb   = 1'b0;
    tx_dat   = 8'h00;
    req_rdy  = '0;
    busy     = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        // Grant only; no byte moves in this cycle.
        if (sel_found) begin
          gnt_nx   = sel_idx;
          count_nx = '0;
`ifdef SERIAL_ARBITER_TAG_EN
          state_nx = S_TAG;
`else
          state_nx = S_DATA;
`endif
        end
      end

`ifdef SERIAL_ARBITER_TAG_EN
      S_TAG: begin
        tx_stb = 1'b1;
        tx_dat = {4'hA, 4'(gnt)};
        if (tx_rdy) begin
          state_nx = S_DATA;
        end
      end
`endif

      S_DATA: begin
        tx_stb       = req_stb[gnt];
        tx_dat       = req_dat[8*gnt +: 8];
        req_rdy[gnt] = tx_rdy;
        if (!req_stb[gnt]) begin
          // Requester dropped out: release the channel, nothing transferred.
          state_nx = S_IDLE;
          ptr_nx   = gnt_inc;
        end else if (tx_rdy) begin
          count_nx = count + 1'b1;
          if (count + 1'b1 == LEN_C) begin
            state_nx = S_IDLE;
            ptr_nx   = gnt_inc;
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
